// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lift_pkg
// Brief    : Shared floor encodings, FSM states and SCAN decision helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lift_pkg;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } lift_state_t;

    typedef struct packed {
        lift_state_t state;
        logic        dir_up;
    } lift_decision_t;

    function automatic logic [3:0] above_mask(input logic [3:0] p);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i] && (j > i)) m[j] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] below_mask(input logic [3:0] p);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i] && (j < i)) m[j] = 1'b1;
        return m;
    endfunction

    // SCAN choice at floor f_pos: serve here, keep direction, else reverse.
    function automatic lift_decision_t decide(
        input logic [3:0] f_pos,
        input logic [3:0] nreq,
        input logic       dir_up,
        input logic       skip_door
    );
        lift_decision_t d;
        logic           above;
        logic           below;
        above    = |(nreq & above_mask(f_pos));
        below    = |(nreq & below_mask(f_pos));
        d.state  = IDLE;
        d.dir_up = dir_up;
        if (!skip_door && |(nreq & f_pos)) begin
            d.state = DOOR;
        end else if (dir_up && above) begin
            d.state  = MOVE_UP;
            d.dir_up = 1'b1;
        end else if (!dir_up && below) begin
            d.state  = MOVE_DOWN;
            d.dir_up = 1'b0;
        end else if (above) begin
            d.state  = MOVE_UP;
            d.dir_up = 1'b1;
        end else if (below) begin
            d.state  = MOVE_DOWN;
            d.dir_up = 1'b0;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_timer.sv
`default_nettype none
// ============================================================================
// Module   : lift_timer
// Brief    : Clearable up-counter with terminal-count compare.
// Revision : 1.0 - initial release
// ============================================================================
module lift_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc_value,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign tc = (r_count == tc_value);

endmodule
`default_nettype wire

// File: rtl/lift_controller.sv
`default_nettype none
// ============================================================================
// Module   : lift_controller
// Brief    : 4-floor lift call latching, SCAN motion scheduling, door timing.
// Revision : 1.0 - initial release
// ============================================================================
module lift_controller #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] pos,
    output logic [3:0] pending,
    output logic       up,
    output logic       down,
    output logic       door_open
);

    import lift_pkg::*;

    localparam int c_max_cycles = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int c_timer_w    = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
    localparam logic [c_timer_w-1:0] c_move_tc = c_timer_w'(MOVE_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_door_tc = c_timer_w'(DOOR_CYCLES - 1);

    lift_state_t          r_state;
    logic                 r_dir_up;
    logic [3:0]           r_pos;
    logic [3:0]           r_pending;
    logic                 r_up;
    logic                 r_down;
    logic                 r_door;

    lift_decision_t       w_dec;
    logic [3:0]           w_nreq;
    logic [3:0]           w_req_latch;
    logic [3:0]           w_next_pos;
    logic [3:0]           w_clr_mask;
    logic                 w_timer_clr;
    logic                 w_tc;
    logic [c_timer_w-1:0] w_tc_value;

    assign w_tc_value = (r_state == DOOR) ? c_door_tc : c_move_tc;

    lift_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_timer_clr),
        .tc_value (w_tc_value),
        .tc       (w_tc)
    );

    always_comb begin
        w_nreq       = r_pending | req;
        w_req_latch  = req;
        w_next_pos   = r_pos;
        w_dec.state  = r_state;
        w_dec.dir_up = r_dir_up;
        w_timer_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                w_dec       = decide(r_pos, w_nreq, r_dir_up, 1'b0);
                w_timer_clr = 1'b1;
            end
            MOVE_UP: begin
                if (w_tc) begin
                    w_next_pos  = r_pos << 1;
                    w_dec       = decide(w_next_pos, w_nreq, r_dir_up, 1'b0);
                    w_timer_clr = 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (w_tc) begin
                    w_next_pos  = r_pos >> 1;
                    w_dec       = decide(w_next_pos, w_nreq, r_dir_up, 1'b0);
                    w_timer_clr = 1'b1;
                end
            end
            DOOR: begin
                // A press at the open floor holds the door instead of queuing a call.
                w_req_latch = req & ~r_pos;
                if (|(req & r_pos)) begin
                    w_timer_clr = 1'b1;
                end else if (w_tc) begin
                    w_dec       = decide(r_pos, w_nreq, r_dir_up, 1'b1);
                    w_timer_clr = 1'b1;
                end
            end
            default: begin
                w_dec.state = IDLE;
                w_timer_clr = 1'b1;
            end
        endcase
        w_clr_mask = (w_dec.state == DOOR) ? w_next_pos : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dir_up  <= 1'b1;
            r_pos     <= FLOOR1;
            r_pending <= 4'b0000;
            r_up      <= 1'b0;
            r_down    <= 1'b0;
            r_door    <= 1'b0;
        end else begin
            r_state   <= w_dec.state;
            r_dir_up  <= w_dec.dir_up;
            r_pos     <= w_next_pos;
            r_pending <= (r_pending | w_req_latch) & ~w_clr_mask;
            r_up      <= (w_dec.state == MOVE_UP);
            r_down    <= (w_dec.state == MOVE_DOWN);
            r_door    <= (w_dec.state == DOOR);
        end
    end

    assign pos       = r_pos;
    assign pending   = r_pending;
    assign up        = r_up;
    assign down      = r_down;
    assign door_open = r_door;

endmodule
`default_nettype wire
